shift_rows_stage: RTL
=====================

# shift_rows_stage

Buffered ShiftRows stage of the AES encrypt round, directly downstream of the SubBytes stage. It accepts one 128-bit state per valid cycle and applies the FIPS-197 row rotation. Results go into a small FIFO, so the following MixColumns/AddRoundKey logic can apply backpressure through a valid/ready handshake. SubBytes has no ready input, so this block absorbs stalls and flags any state it had to drop.

## Interface
- DATA_WIDTH, 128, state width in bits; only 128 is supported.
- FIFO_DEPTH, 4, number of buffered states; power of two, minimum 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- shiftrows_valid_in  input  1  input state is valid this cycle; connects to SubBytes valid_out.
- shiftrows_data_in  input  DATA_WIDTH  input state; ignored when valid_in is low.
- shiftrows_data_out  output  DATA_WIDTH  head-of-FIFO transformed state.
- shiftrows_valid_out  output  1  data_out holds a valid state.
- shiftrows_ready_in  input  1  downstream accepts data_out this cycle.
- shiftrows_count  output  $clog2(FIFO_DEPTH)+1  number of states currently buffered.
- shiftrows_overflow  output  1  sticky flag: at least one input state was dropped.

## Operation
- Byte mapping follows FIPS-197. Byte k = data[127-8k -: 8], and s[r,c] = byte 4c+r. The forward transform is s'[r,c] = s[r,(c+r) mod 4]. Row 0 is unchanged; rows 1, 2 and 3 rotate left by 1, 2 and 3.
- The transform is applied combinationally to data_in. The transformed value is written to the FIFO; the FIFO never stores untransformed data.
- push = valid_in && (count < FIFO_DEPTH || pop). pop = valid_out && ready_in.
- Full with a simultaneous pop: both the push and the pop occur, and count is unchanged.
- Full without a pop: the input is dropped, overflow is set, and count is unchanged.
- overflow stays high until reset. It is not cleared by any other event.
- Empty: valid_out = 0. data_out holds its last value and has no meaning.
- Read and write pointers wrap modulo FIFO_DEPTH. Count is kept as a separate saturating-free counter in the range 0..FIFO_DEPTH.
- Reset values: data_out = 0, valid_out = 0, count = 0, overflow = 0, both pointers = 0.
- Reset mid-operation flushes all buffered states. Nothing is replayed after reset.

## Timing
- Latency is 1 cycle. A state pushed into an empty FIFO at edge N appears on data_out with valid_out = 1 after edge N.
- Throughput is one state per cycle when ready_in is held high. No bubbles occur at full depth.
- data_out and valid_out are driven from registered FIFO storage and pointers, and the output mux uses only registered values. There is no combinational path from data_in or valid_in to any output.
- ready_in may depend combinationally on valid_out. ready_in has no effect on the input side within the same cycle, except that it enables the full-with-pop push.
- The count update follows the same edge as push/pop: +1 for push only, -1 for pop only, 0 for both or neither.

## Configuration
- SHIFT_ROWS_INV_EN defined:
  - Adds an input port shiftrows_inv_in (1 bit), sampled together with valid_in.
  - When inv_in = 1, the InvShiftRows transform s'[r,c] = s[r,(c-r) mod 4] is applied before the push.
  - The mode is captured per state, so mixed forward and inverse states may be in flight at the same time.
- SHIFT_ROWS_INV_EN undefined: the port is absent and only the forward transform is built.

## Structure
- Package aes_pkg holds:
  - AES_BLOCK_W = 128 and AES_NUM_BYTES = 16.
  - Typedef aes_state_t (logic [127:0]).
  - Functions shift_rows_fwd and shift_rows_inv (the inverse under SHIFT_ROWS_INV_EN).
- Sub-module aes_block_fifo is a generic synchronous FIFO of aes_state_t with push/pop, count, registered head, and async active-low reset. This stage instantiates it and adds the transform and the overflow logic.

## Test plan
- Single state: valid_in pulse with d42711aee0bf98f1b8b45de51e415230 and ready_in = 1. Expect data_out = d4bf5d30e0b452aeb84111f11e2798e5 with valid_out high exactly one cycle after the push. Expect count to go 0→1→0.
- Streaming: 11 back-to-back states with ready_in = 1. Expect 11 outputs in order, each one cycle after its input, with count ≤ 1 and overflow = 0.
- Backpressure: ready_in = 0 while 5 states arrive with FIFO_DEPTH = 4.
  - Expect count = 4, the 5th state dropped, and overflow = 1.
  - Then raise ready_in: expect exactly the first 4 states, in order, and overflow still 1.
- Full with simultaneous pop: fill to 4, then assert valid_in and ready_in in the same cycle. Expect count to stay at 4, overflow = 0, and the new state to come out last.
- Reset mid-operation: with 3 states buffered, pulse rst low asynchronously between edges. Expect valid_out = 0, count = 0, overflow = 0 and data_out = 0 immediately. Expect no stale output after release.
- With SHIFT_ROWS_INV_EN: push d4bf5d30e0b452aeb84111f11e2798e5 with inv_in = 1. Expect d42711aee0bf98f1b8b45de51e415230.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared types and ShiftRows helpers.
// SHIFT_ROWS_INV_EN: also builds the InvShiftRows helper.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_NUM_BYTES = 16;

    typedef logic [AES_BLOCK_W-1:0] aes_state_t;

    // Byte k sits at [127-8k -: 8]; s[r,c] is byte 4c+r.
    // Forward: s'[r,c] = s[r,(c+r) mod 4].
    function automatic aes_state_t shift_rows_fwd(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int k = 0; k < AES_NUM_BYTES; k++) begin
            int c, r, src;
            c   = k / 4;
            r   = k % 4;
            src = 4 * ((c + r) % 4) + r;
            o[AES_BLOCK_W-1-8*k -: 8] = s[AES_BLOCK_W-1-8*src -: 8];
        end
        return o;
    endfunction

`ifdef SHIFT_ROWS_INV_EN
    // Inverse: s'[r,c] = s[r,(c-r) mod 4].
    function automatic aes_state_t shift_rows_inv(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int k = 0; k < AES_NUM_BYTES; k++) begin
            int c, r, src;
            c   = k / 4;
            r   = k % 4;
            src = 4 * ((c - r + 4) % 4) + r;
            o[AES_BLOCK_W-1-8*k -: 8] = s[AES_BLOCK_W-1-8*src -: 8];
        end
        return o;
    endfunction
`endif

endpackage

// File: rtl/aes_block_fifo.sv
// Generic synchronous FIFO of AES states with a registered head word.
// The caller guarantees push only when not full (or full with pop) and
// pop only when valid.
module aes_block_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  aes_state_t    i_din,
    output aes_state_t    o_head,
    output logic          o_valid,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    aes_state_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    aes_state_t    r_head;

    logic [PW-1:0] w_rd_next;
    logic [CW-1:0] w_count_next;
    aes_state_t    w_head_next;

    // Next read pointer, occupancy and head word after this edge.
    // The head is the incoming word only when it lands in the slot
    // the read pointer will point at (FIFO empty after any pop).
    always_comb begin
        w_rd_next    = i_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_count_next = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
        w_head_next = r_head;
        if (w_count_next != '0) begin
            if (i_push && (r_wr_ptr == w_rd_next))
                w_head_next = i_din;
            else
                w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage array; cleared on reset so nothing survives a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/shift_rows_stage.sv
// Buffered AES ShiftRows stage: transform on input, FIFO toward
// MixColumns, sticky overflow when SubBytes pushes into a full buffer.
// SHIFT_ROWS_INV_EN: adds shiftrows_inv_in to select InvShiftRows per state.
module shift_rows_stage
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          shiftrows_valid_in,
    input  logic [DATA_WIDTH-1:0]         shiftrows_data_in,
    output logic [DATA_WIDTH-1:0]         shiftrows_data_out,
    output logic                          shiftrows_valid_out,
    input  logic                          shiftrows_ready_in,
    output logic [$clog2(FIFO_DEPTH):0]   shiftrows_count,
    output logic                          shiftrows_overflow
`ifdef SHIFT_ROWS_INV_EN
    ,
    input  logic                          shiftrows_inv_in
`endif
);

    aes_state_t w_xform;
    aes_state_t w_head;
    logic       w_valid;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;
    logic       r_overflow;

    // Transform before storage; the mode travels with each state.
    always_comb begin
`ifdef SHIFT_ROWS_INV_EN
        w_xform = shiftrows_inv_in ? shift_rows_inv(shiftrows_data_in)
                                   : shift_rows_fwd(shiftrows_data_in);
`else
        w_xform = shift_rows_fwd(shiftrows_data_in);
`endif
    end

    // A full FIFO still accepts a state when its head leaves this cycle.
    assign w_pop  = w_valid && shiftrows_ready_in;
    assign w_push = shiftrows_valid_in && (!w_full || w_pop);
    assign w_drop = shiftrows_valid_in && w_full && !w_pop;

    aes_block_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_xform),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (shiftrows_count),
        .o_full  (w_full)
    );

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end

    assign shiftrows_data_out  = w_head;
    assign shiftrows_valid_out = w_valid;
    assign shiftrows_overflow  = r_overflow;

endmodule
